// File: rtl/draw_cell_highlight_if.sv
// draw_cell_highlight_if
//
// VGA timing bus plus pixel colour, as carried between stages of the draw
// chain. One pixel moves per pclk. There is no valid/ready pair: every
// cycle carries a pixel and no stage can stall.
//
// Members:
//   hcount, vcount  11  pixel counters
//   hsync, vsync     1  sync strobes
//   hblnk, vblnk     1  blanking strobes
//   rgb             12  pixel colour
// Modports:
//   master  drives the bus (the stage producing it)
//   slave   reads the bus (the stage consuming it)

interface draw_cell_highlight_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_cell_highlight.sv
// draw_cell_highlight
//
// Draws a fill or border highlight over one cell of a GRID_N x GRID_N
// board and optionally blinks it with a frame-counted half-period. The
// selected cell, its enable and the border mode are latched only on the
// rising edge of vsync, so a highlight never tears mid-frame.
//
// Ports:
//   pclk          pixel clock, rising edge
//   rst           asynchronous active-high reset
//   vin           timing bus + rgb from the previous draw stage
//   vout          registered timing bus + overlaid rgb (1 pclk latency)
//   start_en      game running (per pixel)
//   choice_en     choice screen active, suppresses highlight (per pixel)
//   hl_en         highlight requested (latched at frame boundary)
//   cell_row/col  selected cell (latched at frame boundary)
//   border_mode   0 = fill, 1 = border only (latched at frame boundary)
//   square_color  highlight colour (per pixel)

module draw_cell_highlight #(
   parameter int GRID_N       = 3,
   parameter int ORIGIN_X     = 90,
   parameter int ORIGIN_Y     = 10,
   parameter int CELL_W       = 249,
   parameter int CELL_H       = 249,
   parameter int BORDER       = 6,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                         pclk,
   input  logic                         rst,
   draw_cell_highlight_if.slave         vin,
   draw_cell_highlight_if.master        vout,
   input  logic                         start_en,
   input  logic                         choice_en,
   input  logic                         hl_en,
   input  logic [3:0]                   cell_row,
   input  logic [3:0]                   cell_col,
   input  logic                         border_mode,
   input  logic [11:0]                  square_color
);

   // A zero blink period still needs a 1-bit counter to keep widths legal.
   localparam int CNT_W = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
   localparam logic [4:0]  GRID_N5  = 5'(GRID_N);
   localparam logic [11:0] BORDER12 = 12'(BORDER);

   logic             vs_d;
   logic             frame_start;
   logic [10:0]      x_lo, x_hi, y_lo, y_hi;
   logic             sel_valid;
   logic [3:0]       sel_row, sel_col;
   logic             sel_border;
   logic [CNT_W-1:0] frm_cnt;
   logic             phase;

   logic [11:0]      x_lo_w, y_lo_w;
   logic [10:0]      nxt_x_lo, nxt_x_hi, nxt_y_lo, nxt_y_hi;
   logic             nxt_valid;
   logic             sel_change;

   logic             in_cell;
   logic             near_edge;
   logic             hit;
   logic             paint;

   assign frame_start = vin.vsync && !vs_d;

   // Geometry of the requested cell, evaluated at 12 bits and truncated.
   always_comb begin
      x_lo_w     = 12'(ORIGIN_X) + 12'(cell_col) * 12'(CELL_W);
      y_lo_w     = 12'(ORIGIN_Y) + 12'(cell_row) * 12'(CELL_H);
      nxt_x_lo   = x_lo_w[10:0];
      nxt_y_lo   = y_lo_w[10:0];
      nxt_x_hi   = 11'(x_lo_w + 12'(CELL_W) - 12'd1);
      nxt_y_hi   = 11'(y_lo_w + 12'(CELL_H) - 12'd1);
      nxt_valid  = hl_en && ({1'b0, cell_row} < GRID_N5) && ({1'b0, cell_col} < GRID_N5);
      sel_change = (nxt_valid != sel_valid) || (cell_row != sel_row) || (cell_col != sel_col);
   end

   // Selection latch and blink state. A new selection restarts the blink
   // in the visible phase so the user sees the move immediately.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vs_d       <= 1'b0;
         x_lo       <= '0;
         x_hi       <= '0;
         y_lo       <= '0;
         y_hi       <= '0;
         sel_valid  <= 1'b0;
         sel_row    <= '0;
         sel_col    <= '0;
         sel_border <= 1'b0;
         frm_cnt    <= '0;
         phase      <= 1'b1;
      end else begin
         vs_d <= vin.vsync;
         if (frame_start) begin
            x_lo       <= nxt_x_lo;
            x_hi       <= nxt_x_hi;
            y_lo       <= nxt_y_lo;
            y_hi       <= nxt_y_hi;
            sel_valid  <= nxt_valid;
            sel_row    <= cell_row;
            sel_col    <= cell_col;
            sel_border <= border_mode;
            if (sel_change) begin
               frm_cnt <= '0;
               phase   <= 1'b1;
            end else if (BLINK_FRAMES == 0) begin
               phase   <= 1'b1;
            end else if (frm_cnt == CNT_LAST) begin
               frm_cnt <= '0;
               phase   <= ~phase;
            end else begin
               frm_cnt <= frm_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Pixel hit. The right/bottom edge test is written as h + BORDER > hi
   // so it cannot underflow when hi < BORDER.
   always_comb begin
      in_cell   = (vin.hcount >= x_lo) && (vin.hcount <= x_hi) &&
                  (vin.vcount >= y_lo) && (vin.vcount <= y_hi);
      near_edge = ({1'b0, vin.hcount} < ({1'b0, x_lo} + BORDER12)) ||
                  (({1'b0, vin.hcount} + BORDER12) > {1'b0, x_hi}) ||
                  ({1'b0, vin.vcount} < ({1'b0, y_lo} + BORDER12)) ||
                  (({1'b0, vin.vcount} + BORDER12) > {1'b0, y_hi});
      hit       = sel_border ? (in_cell && near_edge) : in_cell;
      paint     = start_en && !choice_en && sel_valid && phase && hit &&
                  !vin.hblnk && !vin.vblnk;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vout.hcount <= '0;
         vout.vcount <= '0;
         vout.hsync  <= 1'b0;
         vout.vsync  <= 1'b0;
         vout.hblnk  <= 1'b0;
         vout.vblnk  <= 1'b0;
         vout.rgb    <= '0;
      end else begin
         vout.hcount <= vin.hcount;
         vout.vcount <= vin.vcount;
         vout.hsync  <= vin.hsync;
         vout.vsync  <= vin.vsync;
         vout.hblnk  <= vin.hblnk;
         vout.vblnk  <= vin.vblnk;
         vout.rgb    <= paint ? square_color : vin.rgb;
      end
   end

endmodule
